mips_memory_arbiter: RTL
========================

# mips_memory_arbiter

Shares the single-ported unified memory between the instruction-fetch stage and the load/store path driven by the control unit's memory-write-enable and load/store categories. One transaction is outstanding at a time. Each transaction is tracked by a small FSM with a response-timeout watchdog. The block sits between the pipeline's fetch and memory stages and the external memory port.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width
- TIMEOUT_CYCLES, 255, maximum wait for mem_ack; valid range 1..255; counter is 8 bits
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- fetch_valid  input  1  fetch read request
- fetch_addr  input  ADDR_WIDTH  fetch address
- fetch_ready  output  1  fetch request accepted this cycle
- fetch_done  output  1  one-cycle response pulse to fetch
- fetch_rdata  output  DATA_WIDTH  fetched word; valid while fetch_done=1
- data_valid  input  1  load/store request
- data_write  input  1  1 = store, 0 = load
- data_addr  input  ADDR_WIDTH  load/store address
- data_wdata  input  DATA_WIDTH  store data
- data_ready  output  1  data request accepted this cycle
- data_done  output  1  one-cycle response pulse to data path
- data_rdata  output  DATA_WIDTH  load data; valid while data_done=1
- mem_req  output  1  memory request, held until mem_ack
- mem_write  output  1  memory write strobe qualifier
- mem_addr  output  ADDR_WIDTH  memory address
- mem_wdata  output  DATA_WIDTH  memory write data
- mem_rdata  input  DATA_WIDTH  memory read data, sampled with mem_ack
- mem_ack  input  1  memory completion, single-cycle
- error  output  1  qualifies the concurrent *_done pulse as a timeout

## Operation
- States: IDLE, BUSY_FETCH, BUSY_DATA.
- **IDLE:**
  - fetch_ready and data_ready are combinational: at most one is high, and only for the granted requester whose valid is high.
  - Fixed priority: data beats fetch, because the data request belongs to the older instruction.
  - On acceptance (valid & ready at an edge), register addr, wdata and write, where write is 0 for fetch. Move to the matching BUSY state and clear the watchdog.
- **BUSY_*:**
  - mem_req=1.
  - mem_addr, mem_wdata and mem_write are driven from the registers and held stable.
  - Both readies are 0.
  - The watchdog increments every cycle that mem_ack=0.
- **mem_ack in BUSY_X:**
  - Capture mem_rdata into X's rdata register.
  - Pulse X_done for one cycle, with error=0.
  - Return to IDLE.
- **Watchdog reaches TIMEOUT_CYCLES:**
  - Deassert mem_req.
  - Pulse X_done with error=1 and X_rdata=0.
  - Return to IDLE.
  - mem_ack and timeout on the same edge: the ack wins.
- mem_ack in IDLE is ignored.
- Store responses: data_done pulses; data_rdata carries the captured mem_rdata and is don't-care.
- Requesters keep valid and request fields stable until ready; the arbiter does not check this.

## Timing
- Reset values:
  - state IDLE, mem_req=0, mem_write=0.
  - mem_addr=0, mem_wdata=0.
  - fetch_done=0, data_done=0, error=0.
  - rdata registers 0, watchdog 0.
  - Readies are therefore 0 unless a valid is high.
- Reset mid-transaction aborts it immediately: mem_req drops asynchronously and no done pulse is issued.
- Accept at edge N → mem_req=1 from N. mem_ack sampled at edge M ≥ N+1 → done=1 in cycle M to M+1.
  - Minimum latency from accept to done is 1 cycle.
  - One IDLE cycle always separates transactions.
- Timeout: done/error assert after TIMEOUT_CYCLES consecutive busy cycles without ack.

## Configuration
- MIPS_MEMORY_ARBITER_ROUND_ROBIN_EN
- Defined:
  - A last_owner register (reset: data) records the owner of each completed or timed-out transaction.
  - When both valids are high in IDLE, grant the requester that is not last_owner.
  - A single valid is always granted.
- Undefined:
  - Fixed data priority, with no last_owner register.
  - Fetch may starve while data_valid stays high.

## Structure
- Shared package mips_memory_pkg holds:
  - the state encoding (IDLE, BUSY_FETCH, BUSY_DATA);
  - the owner encoding (FETCH, DATA);
  - the default TIMEOUT_CYCLES constant.
- Sub-module mips_memory_arbiter_watchdog: 8-bit counter with clear, enable and an expired output compared against TIMEOUT_CYCLES.

## Test plan
- Fetch only: fetch_addr=0x40, mem_ack 3 cycles later with rdata=0x2108000A → fetch_done one cycle, fetch_rdata=0x2108000A, error=0.
- Both valid, data store to 0x100 with 0xDEADBEEF → data granted first, mem_write=1. Fetch granted in the IDLE cycle after data_done (fixed priority); with ROUND_ROBIN_EN and last_owner=data, fetch is granted first.
- mem_ack never asserted with TIMEOUT_CYCLES=4 → data_done and error high one cycle after the 4th busy cycle, data_rdata=0, mem_req low, then IDLE.
- mem_ack on the same edge as timeout expiry → normal completion, error=0.
- reset asserted while mem_req=1 → mem_req=0 without waiting for a clock edge, no done pulse; a fetch after release completes normally.
- Stray mem_ack in IDLE → no done pulse, state stays IDLE.

Source files
------------

// File: rtl/mips_memory_pkg.sv
// Shared definitions for the MIPS memory arbiter: FSM state encoding,
// transaction owner encoding and the default response timeout.
package mips_memory_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_BUSY_FETCH = 2'd1,
    ST_BUSY_DATA  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/mips_memory_arbiter_if.sv
// Bundle of the fetch, load/store and external memory port signals.
// The slave modport is the arbiter's view; master is the pipeline/memory view.
interface mips_memory_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  fetch_valid;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_ready;
  logic                  fetch_done;
  logic [DATA_WIDTH-1:0] fetch_rdata;

  logic                  data_valid;
  logic                  data_write;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic [DATA_WIDTH-1:0] data_wdata;
  logic                  data_ready;
  logic                  data_done;
  logic [DATA_WIDTH-1:0] data_rdata;

  logic                  mem_req;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  logic                  error;

  modport slave (
    input  fetch_valid, fetch_addr,
    input  data_valid, data_write, data_addr, data_wdata,
    input  mem_rdata, mem_ack,
    output fetch_ready, fetch_done, fetch_rdata,
    output data_ready, data_done, data_rdata,
    output mem_req, mem_write, mem_addr, mem_wdata,
    output error
  );

  modport master (
    output fetch_valid, fetch_addr,
    output data_valid, data_write, data_addr, data_wdata,
    output mem_rdata, mem_ack,
    input  fetch_ready, fetch_done, fetch_rdata,
    input  data_ready, data_done, data_rdata,
    input  mem_req, mem_write, mem_addr, mem_wdata,
    input  error
  );
endinterface

// File: rtl/mips_memory_arbiter_watchdog.sv
// Response watchdog: 8-bit busy-cycle counter. expired_o flags that the
// current busy cycle is the TIMEOUT_CYCLES-th one without an ack, so the
// owning FSM can end the transaction at the coming edge.
module mips_memory_arbiter_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  logic [7:0] cnt_q, cnt_d;

  // Clear has priority over counting; count only while waiting for an ack.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = 8'd0;
    else if (en_i) cnt_d = cnt_q + 8'd1;
  end

  // Counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = ({1'b0, cnt_q} + 9'd1) == 9'(TIMEOUT_CYCLES);

endmodule

// File: rtl/mips_memory_arbiter.sv
// Single-outstanding arbiter between instruction fetch and load/store for a
// single-ported unified memory, with a response timeout watchdog.
// Optional feature macro: MIPS_MEMORY_ARBITER_ROUND_ROBIN_EN (alternate the
// grant on contention instead of fixed data priority).
module mips_memory_arbiter
  import mips_memory_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  mips_memory_arbiter_if.slave  bus
);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic                  fetch_done_q, fetch_done_d;
  logic                  data_done_q, data_done_d;
  logic                  error_q, error_d;
  logic [DATA_WIDTH-1:0] fetch_rdata_q, fetch_rdata_d;
  logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;

  logic grant_fetch, grant_data;
  logic fetch_ready, data_ready;
  logic busy, wd_clr, wd_en, wd_expired;

`ifdef MIPS_MEMORY_ARBITER_ROUND_ROBIN_EN
  owner_e last_owner_q, last_owner_d;

  // Contention goes to whoever did not own the last finished transaction.
  always_comb begin
    grant_data  = bus.data_valid &
                  (!bus.fetch_valid || (last_owner_q == OWN_FETCH));
    grant_fetch = bus.fetch_valid && !grant_data;
  end
`else
  // Data belongs to the older instruction, so it always wins contention.
  always_comb begin
    grant_data  = bus.data_valid;
    grant_fetch = bus.fetch_valid && !bus.data_valid;
  end
`endif

  assign busy  = (state_q != ST_IDLE);
  assign wd_en = busy && !bus.mem_ack;

  mips_memory_arbiter_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );

  // Next-state, request capture, completion and timeout handling.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    write_d       = write_q;
    fetch_done_d  = 1'b0;
    data_done_d   = 1'b0;
    error_d       = 1'b0;
    fetch_rdata_d = fetch_rdata_q;
    data_rdata_d  = data_rdata_q;
    fetch_ready   = 1'b0;
    data_ready    = 1'b0;
    wd_clr        = 1'b0;
`ifdef MIPS_MEMORY_ARBITER_ROUND_ROBIN_EN
    last_owner_d  = last_owner_q;
`endif
    case (state_q)
      ST_IDLE: begin
        data_ready  = grant_data;
        fetch_ready = grant_fetch;
        if (grant_data) begin
          addr_d  = bus.data_addr;
          wdata_d = bus.data_wdata;
          write_d = bus.data_write;
          wd_clr  = 1'b1;
          state_d = ST_BUSY_DATA;
        end else if (grant_fetch) begin
          addr_d  = bus.fetch_addr;
          write_d = 1'b0;
          wd_clr  = 1'b1;
          state_d = ST_BUSY_FETCH;
        end
      end
      ST_BUSY_FETCH: begin
        if (bus.mem_ack || wd_expired) begin
          // An ack on the expiry edge still counts as a normal completion.
          fetch_rdata_d = bus.mem_ack ? bus.mem_rdata : '0;
          error_d       = !bus.mem_ack;
          fetch_done_d  = 1'b1;
          state_d       = ST_IDLE;
`ifdef MIPS_MEMORY_ARBITER_ROUND_ROBIN_EN
          last_owner_d  = OWN_FETCH;
`endif
        end
      end
      ST_BUSY_DATA: begin
        if (bus.mem_ack || wd_expired) begin
          data_rdata_d  = bus.mem_ack ? bus.mem_rdata : '0;
          error_d       = !bus.mem_ack;
          data_done_d   = 1'b1;
          state_d       = ST_IDLE;
`ifdef MIPS_MEMORY_ARBITER_ROUND_ROBIN_EN
          last_owner_d  = OWN_DATA;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      write_q       <= 1'b0;
      fetch_done_q  <= 1'b0;
      data_done_q   <= 1'b0;
      error_q       <= 1'b0;
      fetch_rdata_q <= '0;
      data_rdata_q  <= '0;
`ifdef MIPS_MEMORY_ARBITER_ROUND_ROBIN_EN
      last_owner_q  <= OWN_DATA;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      write_q       <= write_d;
      fetch_done_q  <= fetch_done_d;
      data_done_q   <= data_done_d;
      error_q       <= error_d;
      fetch_rdata_q <= fetch_rdata_d;
      data_rdata_q  <= data_rdata_d;
`ifdef MIPS_MEMORY_ARBITER_ROUND_ROBIN_EN
      last_owner_q  <= last_owner_d;
`endif
    end
  end

  assign bus.fetch_ready = fetch_ready;
  assign bus.data_ready  = data_ready;
  assign bus.fetch_done  = fetch_done_q;
  assign bus.data_done   = data_done_q;
  assign bus.fetch_rdata = fetch_rdata_q;
  assign bus.data_rdata  = data_rdata_q;
  assign bus.error       = error_q;
  assign bus.mem_req     = busy;
  assign bus.mem_write   = write_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;

endmodule
